// File: rtl/des_byte_serializer.sv
// des_byte_serializer: buffers 64-bit DES output blocks and streams them out
// MSB-first as bytes over a valid/accept handshake. Blocks that arrive while
// the buffer is full (and no pop happens on the same edge) are dropped and
// latched in a sticky overflow flag.
module des_byte_serializer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [0:63]              data_i,
  input  logic                     valid_i,
  output logic [7:0]               data_o,
  output logic                     valid_o,
  input  logic                     accept_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [LW-1:0] LVL_ZERO  = LW'(0);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

  // Block storage; index 63 holds bit 0 (the MSB) of the incoming block.
  logic [63:0]   mem_r [DEPTH];
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [LW-1:0] level_r;
  logic [2:0]    k_r;
  logic          overflow_r;

  logic          non_empty_s;
  logic          full_s;
  logic          xfer_s;
  logic          pop_s;
  logic          wr_s;
  logic          drop_s;
  logic [63:0]   head_word_s;
  logic [63:0]   shifted_s;
  logic [7:0]    byte_s;

  // Handshake decode, write/drop decision and head-byte selection.
  always_comb begin
    non_empty_s = (level_r != LVL_ZERO);
    full_s      = (level_r == LVL_FULL);
    xfer_s      = non_empty_s & accept_i;
    pop_s       = xfer_s & (k_r == 3'd7);
    // A full buffer still takes a block when the head is leaving on this edge.
    wr_s        = valid_i & (~full_s | pop_s);
    drop_s      = valid_i & full_s & ~pop_s;
    head_word_s = mem_r[head_r];
    shifted_s   = head_word_s << {k_r, 3'b000};
    if (non_empty_s) begin
      byte_s = shifted_s[63:56];
    end else begin
      byte_s = 8'h00;
    end
  end

  // Storage write; the array itself carries no reset.
  always_ff @(posedge clk_i) begin
    if (wr_s && reset_i) begin
      mem_r[tail_r] <= data_i;
    end
  end

  // Pointers, occupancy, byte index and sticky overflow.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      head_r     <= {AW{1'b0}};
      tail_r     <= {AW{1'b0}};
      level_r    <= LVL_ZERO;
      k_r        <= 3'd0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      // k wraps from 7 to 0 naturally in three bits.
      if (xfer_s) begin
        k_r <= k_r + 3'd1;
      end
      case ({wr_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign data_o     = byte_s;
  assign valid_o    = non_empty_s;
  assign level_o    = level_r;
  assign overflow_o = overflow_r;

endmodule

// File: tb/tb_des_byte_serializer.sv
// Directed bench for des_byte_serializer: a per-cycle vector table for the
// single-block and stall cases, then hand sequences for fill/overflow,
// write/pop collision, a continuous stream and reset mid-block.
module tb_des_byte_serializer;

  localparam int DEPTH = 4;
  localparam logic [63:0] BLK_A = 64'h95F8A5E5DD31D900;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [0:63] data_i;
  logic        valid_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        accept_i;
  logic [2:0]  level_o;
  logic        overflow_o;

  int n_cmp  = 0;
  int n_fail = 0;

  des_byte_serializer #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .accept_i   (accept_i),
    .level_o    (level_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        a;
    logic        ev;
    logic [7:0]  ed;
    logic [2:0]  el;
    logic        eo;
  } vec_t;

  vec_t        tbl [13];
  logic [63:0] bk  [5];
  logic [63:0] st  [64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte j of a block, byte 0 being the most significant.
  function automatic logic [7:0] byte_of(input logic [63:0] w, input int j);
    logic [63:0] s;
    s = w << (8 * j);
    return s[63:56];
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fill4();
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; data_i = bk[i]; accept_i = 1'b0;
      step();
    end
    valid_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b0; valid_i = 1'b0; data_i = 64'h0; accept_i = 1'b0;
    for (int i = 0; i < 5; i++) bk[i] = 64'h0102030405060708 + 64'(i) * 64'h1111111111111111;
    for (int i = 0; i < 64; i++) st[i] = 64'h0123456789ABCDEF ^ (64'(i) * 64'h9E3779B97F4A7C15);

    // per-cycle table: inputs before the edge, outputs expected after it
    tbl[0]  = '{1'b1, BLK_A, 1'b1, 1'b1, 8'h95, 3'd1, 1'b0};
    tbl[1]  = '{1'b0, 64'h0, 1'b1, 1'b1, 8'hF8, 3'd1, 1'b0};
    tbl[2]  = '{1'b0, 64'h0, 1'b1, 1'b1, 8'hA5, 3'd1, 1'b0};
    tbl[3]  = '{1'b0, 64'h0, 1'b0, 1'b1, 8'hA5, 3'd1, 1'b0};
    tbl[4]  = '{1'b0, 64'h0, 1'b0, 1'b1, 8'hA5, 3'd1, 1'b0};
    tbl[5]  = '{1'b0, 64'h0, 1'b0, 1'b1, 8'hA5, 3'd1, 1'b0};
    tbl[6]  = '{1'b0, 64'h0, 1'b1, 1'b1, 8'hE5, 3'd1, 1'b0};
    tbl[7]  = '{1'b0, 64'h0, 1'b1, 1'b1, 8'hDD, 3'd1, 1'b0};
    tbl[8]  = '{1'b0, 64'h0, 1'b1, 1'b1, 8'h31, 3'd1, 1'b0};
    tbl[9]  = '{1'b0, 64'h0, 1'b1, 1'b1, 8'hD9, 3'd1, 1'b0};
    tbl[10] = '{1'b0, 64'h0, 1'b1, 1'b1, 8'h00, 3'd1, 1'b0};
    tbl[11] = '{1'b0, 64'h0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[12] = '{1'b0, 64'h0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};

    // reset state
    #12;
    chk("rst_valid", 64'(valid_o), 64'h0);
    chk("rst_data", 64'(data_o), 64'h0);
    chk("rst_level", 64'(level_o), 64'h0);
    chk("rst_ovf", 64'(overflow_o), 64'h0);
    #1 reset_i = 1'b1;

    // single block with a 3-cycle stall on A5
    for (int i = 0; i < 13; i++) begin
      valid_i = tbl[i].v; data_i = tbl[i].d; accept_i = tbl[i].a;
      step();
      chk($sformatf("tbl%0d_valid", i), 64'(valid_o), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i), 64'(data_o), 64'(tbl[i].ed));
      chk($sformatf("tbl%0d_level", i), 64'(level_o), 64'(tbl[i].el));
      chk($sformatf("tbl%0d_ovf", i), 64'(overflow_o), 64'(tbl[i].eo));
    end
    valid_i = 1'b0; accept_i = 1'b0;

    // burst fill then overflow drop, drain yields first four blocks
    fill4();
    chk("fill_level", 64'(level_o), 64'd4);
    chk("fill_ovf", 64'(overflow_o), 64'd0);
    valid_i = 1'b1; data_i = bk[4];
    step();
    valid_i = 1'b0;
    chk("drop_level", 64'(level_o), 64'd4);
    chk("drop_ovf", 64'(overflow_o), 64'd1);
    accept_i = 1'b1;
    for (int j = 0; j < 32; j++) begin
      chk($sformatf("drain_b%0d", j), 64'(data_o), 64'(byte_of(bk[j / 8], j % 8)));
      chk("drain_valid", 64'(valid_o), 64'd1);
      step();
    end
    chk("drain_empty", 64'(valid_o), 64'd0);
    chk("drain_level", 64'(level_o), 64'd0);
    chk("ovf_sticky", 64'(overflow_o), 64'd1);
    accept_i = 1'b0;

    // reset clears overflow; valid_i ignored while in reset
    #2 reset_i = 1'b0;
    #1;
    chk("rst2_ovf", 64'(overflow_o), 64'd0);
    valid_i = 1'b1; data_i = bk[0];
    step();
    chk("rst_ign_level", 64'(level_o), 64'd0);
    chk("rst_ign_valid", 64'(valid_o), 64'd0);
    valid_i = 1'b0;
    reset_i = 1'b1;

    // write/pop collision while full
    fill4();
    accept_i = 1'b1;
    for (int j = 0; j < 7; j++) step();
    chk("coll_pre_data", 64'(data_o), 64'(byte_of(bk[0], 7)));
    valid_i = 1'b1; data_i = bk[4];
    step();
    valid_i = 1'b0;
    chk("coll_level", 64'(level_o), 64'd4);
    chk("coll_ovf", 64'(overflow_o), 64'd0);
    for (int j = 0; j < 32; j++) begin
      chk($sformatf("coll_b%0d", j), 64'(data_o), 64'(byte_of(bk[1 + j / 8], j % 8)));
      step();
    end
    chk("coll_empty", 64'(level_o), 64'd0);

    // back-to-back stream, one block every 8 cycles
    for (int t = 0; t < 512; t++) begin
      valid_i = ((t % 8) == 0); data_i = st[t / 8]; accept_i = 1'b1;
      step();
      chk($sformatf("st_b%0d", t), 64'(data_o), 64'(byte_of(st[t / 8], t % 8)));
      chk("st_valid", 64'(valid_o), 64'd1);
      chk("st_level", 64'((level_o >= 3'd1) && (level_o <= 3'd2)), 64'd1);
    end
    valid_i = 1'b0;
    step();
    chk("st_end_valid", 64'(valid_o), 64'd0);
    chk("st_end_level", 64'(level_o), 64'd0);

    // reset mid-block, new block restarts at byte 0
    valid_i = 1'b1; data_i = BLK_A; accept_i = 1'b1;
    step();
    valid_i = 1'b0;
    for (int j = 0; j < 4; j++) step();
    chk("mid_b4", 64'(data_o), 64'h0DD);
    #2 reset_i = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(valid_o), 64'd0);
    chk("mid_rst_data", 64'(data_o), 64'd0);
    chk("mid_rst_level", 64'(level_o), 64'd0);
    #3 reset_i = 1'b1;
    valid_i = 1'b1; data_i = bk[2];
    step();
    valid_i = 1'b0;
    chk("mid_new_b0", 64'(data_o), 64'(byte_of(bk[2], 0)));
    chk("mid_new_level", 64'(level_o), 64'd1);
    chk("mid_new_ovf", 64'(overflow_o), 64'd0);
    step();
    chk("mid_new_b1", 64'(data_o), 64'(byte_of(bk[2], 1)));
    for (int j = 0; j < 7; j++) step();
    chk("mid_end_level", 64'(level_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
